// File: rtl/input_pkg.sv
// Shared types and default key codes for the player input controller.
package input_pkg;

    typedef enum logic [1:0] {
        MOVE_NONE  = 2'b00,
        MOVE_LEFT  = 2'b01,
        MOVE_RIGHT = 2'b10
    } move_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_REQ  = 2'b01,
        ARB_HOLD = 2'b10
    } arb_state_t;

    localparam logic [8:0]  DEF_P1_LEFT   = 9'h06B;
    localparam logic [8:0]  DEF_P1_RIGHT  = 9'h074;
    localparam logic [8:0]  DEF_P1_FIRE   = 9'h075;
    localparam logic [8:0]  DEF_P2_LEFT   = 9'h01C;
    localparam logic [8:0]  DEF_P2_RIGHT  = 9'h023;
    localparam logic [8:0]  DEF_P2_FIRE   = 9'h029;
    localparam logic [8:0]  DEF_KEY_PAUSE = 9'h058;
    localparam logic [15:0] DEF_COOLDOWN  = 16'd25000;

    localparam int unsigned NUM_KEYS = 6;

endpackage

// File: rtl/key_dir_resolver.sv
// Resolves one player's left/right held flags into a registered move code,
// giving priority to the most recently pressed key.
module key_dir_resolver
    import input_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       left_held,
    input  logic       right_held,
    input  logic       force_none,
    output logic [1:0] move
);

    logic  left_prev;
    logic  right_prev;
    logic  last_right;
    logic  last_right_next;
    move_t move_next;

    // Press order keeps tracking while forced idle so release behaviour stays correct.
    always_comb begin
        last_right_next = last_right;
        if (left_held && !left_prev) begin
            last_right_next = 1'b0;
        end else if (right_held && !right_prev) begin
            last_right_next = 1'b1;
        end

        move_next = MOVE_NONE;
        if (force_none) begin
            move_next = MOVE_NONE;
        end else if (left_held && right_held) begin
            move_next = last_right_next ? MOVE_RIGHT : MOVE_LEFT;
        end else if (left_held) begin
            move_next = MOVE_LEFT;
        end else if (right_held) begin
            move_next = MOVE_RIGHT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            left_prev  <= 1'b0;
            right_prev <= 1'b0;
            last_right <= 1'b0;
            move       <= MOVE_NONE;
        end else begin
            left_prev  <= left_held;
            right_prev <= right_held;
            last_right <= last_right_next;
            move       <= move_next;
        end
    end

endmodule

// File: rtl/player_input_ctrl.sv
// Keyboard-driven player controls: per-key held flags, direction resolution,
// pause toggle and a round-robin shot arbiter with per-player cooldown.
module player_input_ctrl
    import input_pkg::*;
#(
    parameter logic [8:0]  P1_LEFT   = DEF_P1_LEFT,
    parameter logic [8:0]  P1_RIGHT  = DEF_P1_RIGHT,
    parameter logic [8:0]  P1_FIRE   = DEF_P1_FIRE,
    parameter logic [8:0]  P2_LEFT   = DEF_P2_LEFT,
    parameter logic [8:0]  P2_RIGHT  = DEF_P2_RIGHT,
    parameter logic [8:0]  P2_FIRE   = DEF_P2_FIRE,
    parameter logic [8:0]  KEY_PAUSE = DEF_KEY_PAUSE,
    parameter logic [15:0] COOLDOWN  = DEF_COOLDOWN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] keyCode,
    input  logic       make,
    input  logic       brakee,
    input  logic       shot_ack,
    output logic [1:0] p1_move,
    output logic [1:0] p2_move,
    output logic       shot_req,
    output logic       shot_player,
    output logic       paused
);

    logic [NUM_KEYS-1:0] key_hit;
    logic [NUM_KEYS-1:0] held;
    logic                pause_hit;
    logic                pause_held;
    logic                pause_toggle;

    logic [1:0]  fire_held;
    logic [1:0]  fire_prev;
    logic [1:0]  fire_rise;
    logic [1:0]  pending;
    logic [1:0]  cd_zero;
    logic [1:0]  eligible;
    logic [15:0] cooldown [2];
    logic        rr_ptr;

    arb_state_t state;
    arb_state_t state_next;
    logic       grant;
    logic       grant_p2;
    logic       serve;

    // Held-flag index order: P1 left/right/fire, then P2 left/right/fire.
    always_comb begin
        key_hit    = '0;
        key_hit[0] = (keyCode == P1_LEFT);
        key_hit[1] = (keyCode == P1_RIGHT);
        key_hit[2] = (keyCode == P1_FIRE);
        key_hit[3] = (keyCode == P2_LEFT);
        key_hit[4] = (keyCode == P2_RIGHT);
        key_hit[5] = (keyCode == P2_FIRE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            held <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                if (key_hit[i]) begin
                    if (brakee) begin
                        held[i] <= 1'b0;
                    end else if (make) begin
                        held[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Auto-repeat makes arrive while the pause key is still held and must not re-toggle.
    assign pause_hit    = (keyCode == KEY_PAUSE);
    assign pause_toggle = pause_hit && make && !brakee && !pause_held;

    always_ff @(posedge clk) begin
        if (reset) begin
            pause_held <= 1'b0;
            paused     <= 1'b0;
        end else begin
            if (pause_hit && brakee) begin
                pause_held <= 1'b0;
            end else if (pause_hit && make) begin
                pause_held <= 1'b1;
            end
            if (pause_toggle) begin
                paused <= !paused;
            end
        end
    end

    key_dir_resolver u_p1_dir (
        .clk        (clk),
        .reset      (reset),
        .left_held  (held[0]),
        .right_held (held[1]),
        .force_none (paused),
        .move       (p1_move)
    );

    key_dir_resolver u_p2_dir (
        .clk        (clk),
        .reset      (reset),
        .left_held  (held[3]),
        .right_held (held[4]),
        .force_none (paused),
        .move       (p2_move)
    );

    assign fire_held = {held[5], held[2]};
    assign fire_rise = fire_held & ~fire_prev;
    assign cd_zero   = {cooldown[1] == '0, cooldown[0] == '0};
    assign eligible  = pending & cd_zero;

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        grant_p2   = 1'b0;
        serve      = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (!paused && (eligible != 2'b00)) begin
                    grant      = 1'b1;
                    grant_p2   = (eligible == 2'b10) || ((eligible == 2'b11) && rr_ptr);
                    state_next = ARB_REQ;
                end
            end
            ARB_REQ: begin
                if (shot_ack) begin
                    serve      = 1'b1;
                    state_next = ARB_HOLD;
                end
            end
            ARB_HOLD: state_next = ARB_IDLE;
            default:  state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign shot_req = (state == ARB_REQ);

    // Serving a player clears its request and reloads its lockout in the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            fire_prev   <= '0;
            pending     <= '0;
            cooldown[0] <= '0;
            cooldown[1] <= '0;
            rr_ptr      <= 1'b0;
            shot_player <= 1'b0;
        end else begin
            fire_prev <= fire_held;
            if (grant) begin
                shot_player <= grant_p2;
                rr_ptr      <= !rr_ptr;
            end
            for (int unsigned p = 0; p < 2; p++) begin
                if (serve && (shot_player == p[0])) begin
                    pending[p]  <= 1'b0;
                    cooldown[p] <= COOLDOWN;
                end else begin
                    if (fire_rise[p] && !paused) begin
                        pending[p] <= 1'b1;
                    end
                    if (!paused && (cooldown[p] != '0)) begin
                        cooldown[p] <= cooldown[p] - 16'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_player_input_ctrl.sv
// Randomized scoreboard bench for player_input_ctrl against a key-list reference model.
module tb_player_input_ctrl;

    localparam logic [8:0] K_P1L = 9'h06B;
    localparam logic [8:0] K_P1R = 9'h074;
    localparam logic [8:0] K_P1F = 9'h075;
    localparam logic [8:0] K_P2L = 9'h01C;
    localparam logic [8:0] K_P2R = 9'h023;
    localparam logic [8:0] K_P2F = 9'h029;
    localparam logic [8:0] K_PZ  = 9'h058;
    localparam int CD = 500;
    localparam logic [8:0] CODES [7] = '{K_P1L, K_P1R, K_P1F, K_P2L, K_P2R, K_P2F, K_PZ};

    logic       clk;
    logic       reset;
    logic [8:0] keyCode;
    logic       make;
    logic       brakee;
    logic       shot_ack;
    logic [1:0] p1_move;
    logic [1:0] p2_move;
    logic       shot_req;
    logic       shot_player;
    logic       paused;

    int checks = 0;
    int errors = 0;

    player_input_ctrl #(
        .COOLDOWN (16'd500)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .keyCode     (keyCode),
        .make        (make),
        .brakee      (brakee),
        .shot_ack    (shot_ack),
        .p1_move     (p1_move),
        .p2_move     (p2_move),
        .shot_req    (shot_req),
        .shot_player (shot_player),
        .paused      (paused)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: held keys, per-player list of held direction keys in press order
    // (newest at the back), pending shots, lockout counters and a shot in flight.
    logic [6:0] exp_q [$];
    bit         grant_q [$];
    bit         m_held [7];
    int         ord1 [$];
    int         ord2 [$];
    bit         m_rose [2];
    bit         m_pend [2];
    int         m_cd [2];
    bit         m_paused, m_busy, m_hold, m_sp, m_ptr;

    task automatic dir_add(input int p, input int d);
        if (p == 0) ord1.push_back(d); else ord2.push_back(d);
    endtask

    task automatic dir_remove(input int p, input int d);
        if (p == 0) begin
            for (int j = 0; j < ord1.size(); j++) if (ord1[j] == d) begin ord1.delete(j); break; end
        end else begin
            for (int j = 0; j < ord2.size(); j++) if (ord2[j] == d) begin ord2.delete(j); break; end
        end
    endtask

    always @(posedge clk) begin : model
        logic [1:0] mv1, mv2;
        bit serve, e0, e1, toggle;
        int gp;
        if (reset) begin
            foreach (m_held[i]) m_held[i] = 1'b0;
            ord1.delete(); ord2.delete();
            m_rose = '{0, 0}; m_pend = '{0, 0}; m_cd = '{0, 0};
            m_paused = 0; m_busy = 0; m_hold = 0; m_sp = 0; m_ptr = 0;
            exp_q.push_back(7'b0);
        end else begin
            mv1 = 2'b00;
            mv2 = 2'b00;
            if (!m_paused && ord1.size() > 0) mv1 = (ord1[ord1.size()-1] == 0) ? 2'b01 : 2'b10;
            if (!m_paused && ord2.size() > 0) mv2 = (ord2[ord2.size()-1] == 0) ? 2'b01 : 2'b10;

            serve = m_busy && shot_ack;
            gp = -1;
            if (!m_busy && !m_hold && !m_paused) begin
                e0 = m_pend[0] && (m_cd[0] == 0);
                e1 = m_pend[1] && (m_cd[1] == 0);
                if (e0 && e1) gp = m_ptr ? 1 : 0;
                else if (e0) gp = 0;
                else if (e1) gp = 1;
            end
            for (int p = 0; p < 2; p++) begin
                if (serve && (int'(m_sp) == p)) begin
                    m_pend[p] = 0;
                    m_cd[p] = CD;
                end else begin
                    if (m_rose[p] && !m_paused) m_pend[p] = 1;
                    if (!m_paused && m_cd[p] > 0) m_cd[p] = m_cd[p] - 1;
                end
            end
            m_hold = serve;
            if (gp >= 0) begin
                m_busy = 1;
                m_sp = (gp == 1);
                m_ptr = !m_ptr;
                grant_q.push_back(gp == 1);
            end else if (serve) begin
                m_busy = 0;
            end

            toggle = (keyCode == K_PZ) && make && !brakee && !m_held[6];
            m_rose = '{0, 0};
            for (int i = 0; i < 7; i++) begin
                if (keyCode == CODES[i]) begin
                    if (brakee) begin
                        if (m_held[i] && i != 6 && (i % 3) != 2) dir_remove(i / 3, i % 3);
                        m_held[i] = 0;
                    end else if (make && !m_held[i]) begin
                        m_held[i] = 1;
                        if (i == 2) m_rose[0] = 1;
                        else if (i == 5) m_rose[1] = 1;
                        else if (i != 6) dir_add(i / 3, i % 3);
                    end
                end
            end
            if (toggle) m_paused = !m_paused;
            exp_q.push_back({mv1, mv2, m_busy, m_sp, m_paused});
        end
    end

    // Monitor: compares every presented output set, and the player on each new shot request.
    bit req_seen = 1'b0;
    always @(negedge clk) begin
        logic [6:0] e;
        bit g;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({p1_move, p2_move, shot_req, shot_player, paused} !== e) begin
                errors++;
                $display("FAIL outputs @%0t: actual p1=%b p2=%b req=%b player=%b paused=%b, required p1=%b p2=%b req=%b player=%b paused=%b",
                         $time, p1_move, p2_move, shot_req, shot_player, paused,
                         e[6:5], e[4:3], e[2], e[1], e[0]);
            end
        end
        if (shot_req && !req_seen) begin
            checks++;
            if (grant_q.size() == 0) begin
                errors++;
                $display("FAIL grant @%0t: actual shot_req=1 player=%b, required no grant", $time, shot_player);
            end else begin
                g = grant_q.pop_front();
                if (shot_player !== g) begin
                    errors++;
                    $display("FAIL grant_player @%0t: actual %b, required %b", $time, shot_player, g);
                end
            end
        end
        req_seen = shot_req;
    end

    task automatic step(input logic [8:0] kc, input logic mk, input logic br, input logic ack);
        keyCode  = kc;
        make     = mk;
        brakee   = br;
        shot_ack = ack;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(9'h000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_req(input int bound);
        int n = 0;
        while (!shot_req && n < bound) begin
            step(9'h000, 1'b0, 1'b0, 1'b0);
            n++;
        end
        checks++;
        if (!shot_req) begin
            errors++;
            $display("FAIL wait_shot_req: actual shot_req=0 after %0d cycles, required 1", bound);
        end
    endtask

    initial begin
        reset = 1'b1;
        step(9'h000, 1'b0, 1'b0, 1'b0);
        step(9'h000, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        idle(2);

        // Direction priority: left, then right overrides, then release right falls back to left.
        step(K_P1L, 1'b1, 1'b0, 1'b0); idle(3);
        step(K_P1R, 1'b1, 1'b0, 1'b0); idle(3);
        step(K_P1R, 1'b0, 1'b1, 1'b0); idle(3);
        step(K_P1L, 1'b0, 1'b1, 1'b0); idle(2);

        // Simultaneous make and brakee: release wins.
        step(K_P2L, 1'b1, 1'b0, 1'b0); idle(2);
        step(K_P2L, 1'b1, 1'b1, 1'b0); idle(2);

        // Both players fire together: P1 served first, then P2 after the hold cycle.
        step(K_P1F, 1'b1, 1'b0, 1'b0);
        step(K_P2F, 1'b1, 1'b0, 1'b0);
        wait_req(20); idle(2); step(9'h000, 1'b0, 1'b0, 1'b1);
        wait_req(20); idle(2); step(9'h000, 1'b0, 1'b0, 1'b1);
        step(K_P1F, 1'b0, 1'b1, 1'b0);
        step(K_P2F, 1'b0, 1'b1, 1'b0);

        // P1 fires again inside its lockout window and waits for it to expire.
        idle(95);
        step(K_P1F, 1'b1, 1'b0, 1'b0);
        wait_req(700); idle(1); step(9'h000, 1'b0, 1'b0, 1'b1);
        step(K_P1F, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of an outstanding request; a late ack must be ignored.
        step(K_P2F, 1'b1, 1'b0, 1'b0);
        wait_req(700);
        reset = 1'b1;
        step(9'h000, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        step(9'h000, 1'b0, 1'b0, 1'b1);
        idle(3);
        step(K_P2F, 1'b0, 1'b1, 1'b0);

        // Pause: make, auto-repeat make, brakee, make; moves held at none while paused.
        step(K_P1R, 1'b1, 1'b0, 1'b0); idle(2);
        step(K_PZ, 1'b1, 1'b0, 1'b0); idle(2);
        step(K_P2R, 1'b1, 1'b0, 1'b0); idle(2);
        step(K_PZ, 1'b1, 1'b0, 1'b0); idle(2);
        step(K_PZ, 1'b0, 1'b1, 1'b0); idle(2);
        step(K_PZ, 1'b1, 1'b0, 1'b0); idle(3);
        step(K_PZ, 1'b0, 1'b1, 1'b0);
        step(K_P1R, 1'b0, 1'b1, 1'b0);
        step(K_P2R, 1'b0, 1'b1, 1'b0);
        idle(2);

        for (int n = 0; n < 6000; n++) begin
            logic [8:0] kc;
            int r;
            r = $urandom_range(0, 99);
            if (r < 88) kc = CODES[$urandom_range(0, 6)];
            else kc = 9'($urandom_range(0, 511));
            reset = ($urandom_range(0, 799) == 0);
            step(kc, ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 2), ($urandom_range(0, 3) == 0));
        end
        reset = 1'b0;
        idle(5);

        checks++;
        if (grant_q.size() != 0) begin
            errors++;
            $display("FAIL grant_queue_drain: actual %0d outstanding grants, required 0", grant_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
